// File: rtl/image_loader_if.sv
// Pixel stream in, image buffer store port out, and CNN start/done handshake for image_loader.
interface image_loader_if #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 10
);
  logic              s_valid;
  logic [PIX_W-1:0]  s_data;
  logic              s_last;
  logic              s_ready;
  logic              store;
  logic [DATA_W-1:0] image_pixel;
  logic              store_finish;
  logic              start;
  logic              infer_done;
  logic              frame_err;
  logic              sat_flag;
  logic [CNT_W-1:0]  pix_count;

  // Upstream / buffer / datapath side
  modport master (
    output s_valid, s_data, s_last, store_finish, infer_done,
    input  s_ready, store, image_pixel, start, frame_err, sat_flag, pix_count
  );

  // Loader side
  modport slave (
    input  s_valid, s_data, s_last, store_finish, infer_done,
    output s_ready, store, image_pixel, start, frame_err, sat_flag, pix_count
  );
endinterface

// File: rtl/image_loader.sv
// Converts one frame of unsigned pixel bytes to saturated signed fixed-point, writes it to the
// image buffer, closes the frame, then holds start until the datapath reports completion.
module image_loader #(
  parameter int unsigned N_PIXELS   = 784,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int          ZERO_POINT = 0,
  parameter int unsigned FRAC_SHIFT = 0
) (
  input  logic          clk,
  input  logic          reset,
  image_loader_if.slave bus
);

  localparam int unsigned EXT_W = DATA_W + PIX_W + 1;
  localparam int unsigned CNT_W = 10;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIXELS);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(PIX_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(PIX_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, PAD, DRAIN, FLUSH, DONE} state_t;

  state_t              state_q;
  logic                s_ready_q;
  logic                store_q;
  logic                start_q;
  logic                frame_err_q;
  logic                sat_flag_q;
  logic [DATA_W-1:0]   pixel_q;
  logic [CNT_W-1:0]    cnt_q;

  logic signed [EXT_W-1:0] ext_c;
  logic signed [EXT_W-1:0] shift_c;
  logic [DATA_W-1:0]       pix_d;
  logic                    sat_d;
  logic                    first_c;
  logic                    xfer_c;
  logic [CNT_W-1:0]        cnt_d;

  assign xfer_c = bus.s_valid & s_ready_q;

  // Byte-to-fixed-point conversion and next pixel count (count restarts on a frame's first byte)
  always_comb begin
    ext_c   = signed'(EXT_W'({1'b0, bus.s_data})) - signed'(EXT_W'(ZERO_POINT));
    shift_c = ext_c <<< FRAC_SHIFT;
    pix_d   = shift_c[DATA_W-1:0];
    sat_d   = 1'b0;
    if (shift_c > SAT_MAX) begin
      pix_d = SAT_MAX[DATA_W-1:0];
      sat_d = 1'b1;
    end else if (shift_c < SAT_MIN) begin
      pix_d = SAT_MIN[DATA_W-1:0];
      sat_d = 1'b1;
    end
    first_c = (state_q == IDLE);
    cnt_d   = (first_c ? '0 : cnt_q) + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      s_ready_q   <= 1'b0;
      store_q     <= 1'b0;
      start_q     <= 1'b0;
      frame_err_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      pixel_q     <= '0;
      cnt_q       <= '0;
    end else begin
      store_q <= 1'b0;
      case (state_q)
        IDLE, LOAD: begin
          s_ready_q <= 1'b1;
          if (xfer_c) begin
            store_q    <= 1'b1;
            pixel_q    <= pix_d;
            cnt_q      <= cnt_d;
            sat_flag_q <= sat_d | (sat_flag_q & ~first_c);
            if (first_c) frame_err_q <= 1'b0;
            if (bus.s_last) begin
              s_ready_q <= 1'b0;
              if (cnt_d == LAST_CNT) begin
                state_q <= FLUSH;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= PAD;
              end
            end else if (cnt_d == LAST_CNT) begin
              frame_err_q <= 1'b1;
              state_q     <= DRAIN;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        // Short frame: fill the remaining buffer slots with zero pixels
        PAD: begin
          store_q <= 1'b1;
          pixel_q <= '0;
          cnt_q   <= cnt_d;
          if (cnt_d == LAST_CNT) state_q <= FLUSH;
        end
        DRAIN: begin
          if (xfer_c && bus.s_last) begin
            s_ready_q <= 1'b0;
            store_q   <= 1'b1;
            pixel_q   <= '0;
            state_q   <= FLUSH;
          end
        end
        // Terminal store cycle is held until the buffer acknowledges
        FLUSH: begin
          if (bus.store_finish) begin
            start_q <= 1'b1;
            state_q <= DONE;
          end else begin
            store_q <= 1'b1;
            pixel_q <= '0;
          end
        end
        DONE: begin
          if (bus.infer_done) begin
            start_q   <= 1'b0;
            s_ready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.store       = store_q;
  assign bus.image_pixel = pixel_q;
  assign bus.start       = start_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.sat_flag    = sat_flag_q;
  assign bus.pix_count   = cnt_q;

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: three instances (default, zp=128/shift=8, zp=128/shift=9) share one stream.
module tb_image_loader;
  localparam int N = 784;

  typedef struct packed {
    logic       timeout;
    logic       start_fin;
    logic       store_fin;
    logic       start_hold;
    logic       start_inf;
    logic       ready_inf;
    logic       err;
    logic [2:0] sat;
    logic [9:0] cnt;
  } fin_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'd0;
  logic       s_last = 1'b0;
  logic       store_finish = 1'b0;
  logic       infer_done = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0] frame_bytes [0:1023];
  int obs0[$], obs1[$], obs2[$], obs_cnt[$];
  int exp0[$], exp1[$], exp2[$];
  bit [2:0] exp_sat;
  bit exp_err;
  int flush_cnt = 0, flush_nz = 0, lat_bad = 0;
  bit lat_en = 1'b0;
  bit prev_xfer = 1'b0;
  logic [9:0] prev_cnt = 10'd0;

  always #5 clk = ~clk;

  image_loader_if bus0 ();
  image_loader_if bus1 ();
  image_loader_if bus2 ();

  assign bus0.s_valid = s_valid;  assign bus0.s_data = s_data;  assign bus0.s_last = s_last;
  assign bus0.store_finish = store_finish;  assign bus0.infer_done = infer_done;
  assign bus1.s_valid = s_valid;  assign bus1.s_data = s_data;  assign bus1.s_last = s_last;
  assign bus1.store_finish = store_finish;  assign bus1.infer_done = infer_done;
  assign bus2.s_valid = s_valid;  assign bus2.s_data = s_data;  assign bus2.s_last = s_last;
  assign bus2.store_finish = store_finish;  assign bus2.infer_done = infer_done;

  image_loader #(.N_PIXELS(N), .PIX_W(8), .DATA_W(16), .ZERO_POINT(0), .FRAC_SHIFT(0))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  image_loader #(.N_PIXELS(N), .PIX_W(8), .DATA_W(16), .ZERO_POINT(128), .FRAC_SHIFT(8))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  image_loader #(.N_PIXELS(N), .PIX_W(8), .DATA_W(16), .ZERO_POINT(128), .FRAC_SHIFT(9))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Capture: a store whose pix_count moved is a frame pixel; otherwise it is a terminal store
  always @(negedge clk) begin
    bit data;
    data = bus0.store && (bus0.pix_count != prev_cnt);
    if (data) begin
      obs0.push_back(int'($signed(bus0.image_pixel)));
      obs1.push_back(int'($signed(bus1.image_pixel)));
      obs2.push_back(int'($signed(bus2.image_pixel)));
      obs_cnt.push_back(int'(bus0.pix_count));
    end else if (bus0.store) begin
      flush_cnt++;
      if (bus0.image_pixel != 16'd0) flush_nz++;
    end
    if (lat_en && (data != prev_xfer)) lat_bad++;
    prev_xfer = s_valid && bus0.s_ready;
    prev_cnt  = bus0.pix_count;
  end

  function automatic int conv(input int b, input int zp, input int fs, inout bit sat);
    int v;
    v = (b - zp) * (1 << fs);
    if (v > 32767) begin sat = 1'b1; return 32767; end
    if (v < -32768) begin sat = 1'b1; return -32768; end
    return v;
  endfunction

  // Expected frame contents: first N accepted bytes, zero padding if s_last came early
  function automatic void model_frame(input int nbytes, input int last_at);
    bit s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    int kept = 0;
    exp0.delete(); exp1.delete(); exp2.delete();
    for (int t = 0; t < nbytes; t++) begin
      if (kept < N) begin
        exp0.push_back(conv(int'(frame_bytes[t]), 0, 0, s0));
        exp1.push_back(conv(int'(frame_bytes[t]), 128, 8, s1));
        exp2.push_back(conv(int'(frame_bytes[t]), 128, 9, s2));
        kept++;
      end
      if (t + 1 == last_at) break;
    end
    if (last_at > 0 && last_at < N) begin
      while (kept < N) begin
        exp0.push_back(0); exp1.push_back(0); exp2.push_back(0);
        kept++;
      end
    end
    exp_sat = {s2, s1, s0};
    exp_err = (last_at != N);
  endfunction

  function automatic int diff_count(input int a[$], input int b[$]);
    int n = 0;
    if (a.size() != b.size()) n++;
    for (int k = 0; k < a.size() && k < b.size(); k++) if (a[k] != b[k]) n++;
    return n;
  endfunction

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < 1024; i++) frame_bytes[i] = 8'($urandom_range(hi, lo));
  endtask

  task automatic send_frame(input int nbytes, input int last_at, input int pct, output int sent);
    int budget = 0;
    logic rdy;
    sent = 0;
    while (sent < nbytes && budget < 20000) begin
      s_valid = (int'($urandom_range(99, 0)) < pct);
      s_data  = frame_bytes[sent];
      s_last  = (sent + 1 == last_at);
      rdy     = bus0.s_ready;
      @(posedge clk); #1;
      budget++;
      if (s_valid && rdy) sent++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic finish_frame(output fin_t f);
    int b = 0;
    f = '0;
    while (!(bus0.store && bus0.pix_count == 10'(N) && !bus0.s_ready) && b < 3000) begin
      @(posedge clk); #1;
      b++;
    end
    f.timeout = (b >= 3000);
    repeat (3) @(posedge clk);
    #1 store_finish = 1'b1;
    @(posedge clk); #1;
    store_finish = 1'b0;
    f.start_fin = bus0.start;
    f.store_fin = bus0.store;
    f.err       = bus0.frame_err;
    f.sat       = {bus2.sat_flag, bus1.sat_flag, bus0.sat_flag};
    f.cnt       = bus0.pix_count;
    repeat (2) @(posedge clk); #1;
    f.start_hold = bus0.start;
    infer_done = 1'b1;
    @(posedge clk); #1;
    infer_done = 1'b0;
    f.start_inf = bus0.start;
    f.ready_inf = bus0.s_ready;
  endtask

  task automatic run_frame(input int nbytes, input int last_at, input int pct, output fin_t f);
    int sent;
    obs0.delete(); obs1.delete(); obs2.delete(); obs_cnt.delete();
    flush_cnt = 0; flush_nz = 0;
    model_frame(nbytes, last_at);
    send_frame(nbytes, last_at, pct, sent);
    finish_frame(f);
    if (sent != nbytes) f.timeout = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;
    total++;
    if ({bus0.s_ready, bus0.store, bus0.image_pixel, bus0.start, bus0.frame_err,
         bus0.sat_flag, bus0.pix_count} !== 31'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {bus0.s_ready, bus0.store,
        bus0.image_pixel, bus0.start, bus0.frame_err, bus0.sat_flag, bus0.pix_count});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus0.s_ready !== 1'b1 || bus0.store !== 1'b0) begin
      bad++; $display("FAIL reset_idle ready=%0d store=%0d want ready=1 store=0", bus0.s_ready, bus0.store);
    end
  endtask

  task automatic test_continuous();
    fin_t f;
    int mm;
    for (int i = 0; i < N; i++) frame_bytes[i] = 8'(i % 256);
    lat_bad = 0; lat_en = 1'b1;
    run_frame(N, N, 100, f);
    lat_en = 1'b0;
    total++; if (f.timeout) begin bad++; $display("FAIL t1_timeout got=1 want=0"); end
    mm = diff_count(obs0, exp0);
    total++; if (mm != 0) begin bad++; $display("FAIL t1_pixels mismatches=%0d size=%0d want 0 size=%0d", mm, obs0.size(), exp0.size()); end
    mm = 0;
    foreach (obs_cnt[k]) if (obs_cnt[k] != k + 1) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL t1_pix_count_seq mismatches=%0d want 0", mm); end
    total++; if (lat_bad != 0) begin bad++; $display("FAIL t1_latency violations=%0d want 0", lat_bad); end
    total++; if (f.start_fin !== 1'b1 || f.store_fin !== 1'b0) begin bad++; $display("FAIL t1_finish start=%0d store=%0d want start=1 store=0", f.start_fin, f.store_fin); end
    total++; if (f.err !== 1'b0) begin bad++; $display("FAIL t1_frame_err got=%0d want=0", f.err); end
    total++; if (f.cnt !== 10'd784) begin bad++; $display("FAIL t1_done_count got=%0d want=784", f.cnt); end
    total++; if (f.sat !== exp_sat) begin bad++; $display("FAIL t1_sat got=%b want=%b", f.sat, exp_sat); end
    total++; if (f.start_hold !== 1'b1) begin bad++; $display("FAIL t1_start_hold got=%0d want=1", f.start_hold); end
    total++; if (f.start_inf !== 1'b0 || f.ready_inf !== 1'b1) begin bad++; $display("FAIL t1_release start=%0d ready=%0d want 0/1", f.start_inf, f.ready_inf); end
    total++; if (flush_cnt < 3 || flush_nz != 0) begin bad++; $display("FAIL t1_terminal cycles=%0d nonzero=%0d want >=3/0", flush_cnt, flush_nz); end
  endtask

  task automatic test_random_valid();
    fin_t f;
    int mm;
    fill_random(0, 255);
    lat_bad = 0; lat_en = 1'b1;
    run_frame(N, N, 50, f);
    lat_en = 1'b0;
    total++; if (f.timeout) begin bad++; $display("FAIL t2_timeout got=1 want=0"); end
    mm = diff_count(obs0, exp0) + diff_count(obs1, exp1) + diff_count(obs2, exp2);
    total++; if (mm != 0) begin bad++; $display("FAIL t2_pixels mismatches=%0d size=%0d want 0 size=%0d", mm, obs0.size(), N); end
    total++; if (lat_bad != 0) begin bad++; $display("FAIL t2_latency violations=%0d want 0", lat_bad); end
    total++; if (obs_cnt.size() == 0 || obs_cnt[0] != 1) begin bad++; $display("FAIL t2_first_count got=%0d want=1", obs_cnt.size() ? obs_cnt[0] : -1); end
    total++; if (f.cnt !== 10'd784 || f.err !== 1'b0) begin bad++; $display("FAIL t2_done count=%0d err=%0d want 784/0", f.cnt, f.err); end
    total++; if (f.sat !== exp_sat) begin bad++; $display("FAIL t2_sat got=%b want=%b", f.sat, exp_sat); end
  endtask

  task automatic test_short_frame();
    fin_t f;
    int mm, z;
    fill_random(0, 255);
    run_frame(100, 100, 80, f);
    total++; if (f.timeout) begin bad++; $display("FAIL t3_timeout got=1 want=0"); end
    mm = diff_count(obs0, exp0) + diff_count(obs2, exp2);
    total++; if (mm != 0) begin bad++; $display("FAIL t3_pixels mismatches=%0d want 0", mm); end
    z = 0;
    for (int k = 100; k < obs0.size(); k++) if (obs0[k] == 0) z++;
    total++; if (z != 684 || obs0.size() != N) begin bad++; $display("FAIL t3_pad zeros=%0d size=%0d want 684/784", z, obs0.size()); end
    total++; if (f.err !== 1'b1) begin bad++; $display("FAIL t3_frame_err got=%0d want=1", f.err); end
    total++; if (f.start_fin !== 1'b1 || f.cnt !== 10'd784) begin bad++; $display("FAIL t3_done start=%0d count=%0d want 1/784", f.start_fin, f.cnt); end
  endtask

  task automatic test_long_frame();
    fin_t f;
    int mm;
    fill_random(64, 191);
    run_frame(790, 790, 100, f);
    total++; if (f.timeout) begin bad++; $display("FAIL t4_timeout got=1 want=0"); end
    mm = diff_count(obs0, exp0) + diff_count(obs1, exp1) + diff_count(obs2, exp2);
    total++; if (mm != 0 || obs0.size() != N) begin bad++; $display("FAIL t4_pixels mismatches=%0d size=%0d want 0/784", mm, obs0.size()); end
    total++; if (f.err !== 1'b1) begin bad++; $display("FAIL t4_frame_err got=%0d want=1", f.err); end
    total++; if (f.sat !== exp_sat) begin bad++; $display("FAIL t4_sat got=%b want=%b", f.sat, exp_sat); end
    total++; if (f.start_fin !== 1'b1) begin bad++; $display("FAIL t4_done start=%0d want=1", f.start_fin); end
  endtask

  task automatic test_conversion();
    fin_t f;
    int mm;
    fill_random(0, 255);
    frame_bytes[0] = 8'd0; frame_bytes[1] = 8'd255; frame_bytes[2] = 8'd128;
    run_frame(N, N, 100, f);
    total++; if (f.timeout) begin bad++; $display("FAIL t5_timeout got=1 want=0"); end
    total++;
    if (obs1.size() < 3 || obs1[0] != -32768 || obs1[1] != 32512 || obs1[2] != 0) begin
      bad++; $display("FAIL t5_shift8 got=%0d,%0d,%0d want=-32768,32512,0", obs1[0], obs1[1], obs1[2]);
    end
    total++; if (obs2.size() < 2 || obs2[1] != 32767) begin bad++; $display("FAIL t5_shift9_sat got=%0d want=32767", obs2[1]); end
    total++; if (f.sat[2] !== 1'b1) begin bad++; $display("FAIL t5_sat_flag got=%0d want=1", f.sat[2]); end
    mm = diff_count(obs0, exp0) + diff_count(obs1, exp1) + diff_count(obs2, exp2);
    total++; if (mm != 0) begin bad++; $display("FAIL t5_pixels mismatches=%0d want 0", mm); end
    total++; if (f.sat !== exp_sat || f.err !== 1'b0) begin bad++; $display("FAIL t5_flags sat=%b err=%0d want %b/0", f.sat, f.err, exp_sat); end
  endtask

  task automatic test_reset_mid_frame();
    fin_t f;
    int sent, mm;
    fill_random(0, 255);
    send_frame(400, 0, 100, sent);
    total++; if (sent != 400) begin bad++; $display("FAIL t6_send got=%0d want=400", sent); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus0.s_ready, bus0.store, bus0.image_pixel, bus0.start, bus0.frame_err,
         bus0.sat_flag, bus0.pix_count} !== 31'd0 || bus2.sat_flag !== 1'b0) begin
      bad++; $display("FAIL t6_reset_outputs got=%h sat2=%0d want=0", {bus0.s_ready, bus0.store,
        bus0.image_pixel, bus0.start, bus0.frame_err, bus0.sat_flag, bus0.pix_count}, bus2.sat_flag);
    end
    reset = 1'b0;
    flush_cnt = 0;
    obs0.delete();
    repeat (3) @(posedge clk); #1;
    total++; if (flush_cnt != 0 || obs0.size() != 0) begin bad++; $display("FAIL t6_no_terminal stores=%0d want 0", flush_cnt + obs0.size()); end
    fill_random(0, 255);
    run_frame(N, N, 70, f);
    total++; if (f.timeout) begin bad++; $display("FAIL t6_timeout got=1 want=0"); end
    mm = diff_count(obs0, exp0) + diff_count(obs1, exp1) + diff_count(obs2, exp2);
    total++; if (mm != 0) begin bad++; $display("FAIL t6_pixels mismatches=%0d want 0", mm); end
    total++; if (obs_cnt.size() == 0 || obs_cnt[0] != 1) begin bad++; $display("FAIL t6_first_count got=%0d want=1", obs_cnt.size() ? obs_cnt[0] : -1); end
    total++; if (f.err !== 1'b0 || f.cnt !== 10'd784 || f.start_fin !== 1'b1) begin bad++; $display("FAIL t6_done err=%0d count=%0d start=%0d want 0/784/1", f.err, f.cnt, f.start_fin); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_random_valid();
    test_short_frame();
    test_long_frame();
    test_conversion();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
